// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: runs one PUF challenge-response transaction.
// It takes a challenge word from the UART receiver and drives it onto the
// PUF challenge bus. It then triggers evaluation, waits a programmable
// settle time and captures the response. Finally it hands the response word
// to the UART transmitter and waits for tx_done.
// Optional build macro PUF_VOTE_EN: the PUF is evaluated NUM_EVAL times and
// each response bit is majority-voted.
module puf_crp_sequencer #(
   parameter int CW         = 16,
   parameter int RW         = 32,
   parameter int SETTLE     = 8,
   parameter int TX_TIMEOUT = 65535,
   parameter int NUM_EVAL   = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_done,
   input  logic [CW-1:0] rx_data,
   input  logic          check,
   input  logic          err_clr,
   output logic [CW-1:0] puf_challenge,
   output logic          puf_trig,
   input  logic [RW-1:0] puf_response,
   output logic          tx_start,
   output logic [RW-1:0] tx_data,
   input  logic          tx_done,
   output logic          busy,
   output logic          err_overrun,
   output logic          err_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      SEND,
      WAIT_TX
   } state_t;

   localparam int SCW = $clog2(SETTLE + 1);
   localparam int TOW = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [TOW-1:0] TO_LAST     = TOW'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

   state_t state, state_next;

   logic           rx_q, tx_q;
   logic           rx_rise, tx_rise;
   logic           mode_chk;
   logic [SCW-1:0] settle_cnt;
   logic [TOW-1:0] to_cnt;
   logic           settle_done;

   // strobes from the next-state logic to the datapath
   logic           accept;
   logic           load_loop;
   logic           sample;
   logic           timeout_hit;
   logic           trig_next;
   logic           start_next;
   logic           overrun_set;
   logic [RW-1:0]  sample_word;

`ifdef PUF_VOTE_EN
   localparam int VW = $clog2(NUM_EVAL + 1);
   localparam logic [VW-1:0] REP_LAST = VW'(NUM_EVAL - 1);
   localparam logic [VW-1:0] HALF     = VW'(NUM_EVAL / 2);

   logic [VW-1:0] rep_cnt;
   logic          rearm;
   logic          last_rep;
   logic [VW-1:0] vote_cnt [RW];
   logic [VW-1:0] vote_sum [RW];
   logic [RW-1:0] vote_word;

   // running per-bit ones count including the response being sampled now
   always_comb begin
      vote_word = '0;
      for (int unsigned i = 0; i < RW; i++) begin
         vote_sum[i]  = vote_cnt[i] + VW'(puf_response[i]);
         vote_word[i] = (vote_sum[i] > HALF);
      end
   end

   assign last_rep    = (rep_cnt == REP_LAST);
   assign settle_done = (state == EVAL) && !rearm && (settle_cnt == SETTLE_LAST);
   assign sample_word = vote_word;
`else
   assign settle_done = (state == EVAL) && (settle_cnt == SETTLE_LAST);
   assign sample_word = puf_response;
`endif

   // current level against the once-registered level
   assign rx_rise     = rx_done & ~rx_q;
   assign tx_rise     = tx_done & ~tx_q;
   assign overrun_set = rx_rise && (state != IDLE);
   assign busy        = (state != IDLE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // next-state decode and strobes for the registered outputs
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      load_loop   = 1'b0;
      sample      = 1'b0;
      timeout_hit = 1'b0;
      trig_next   = puf_trig;
      start_next  = 1'b0;
      case (state)
         IDLE: begin
            if (rx_rise) begin
               accept     = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (mode_chk) begin
               load_loop  = 1'b1;
               state_next = SEND;
            end else begin
               trig_next  = 1'b1;
               state_next = EVAL;
            end
         end
         EVAL: begin
`ifdef PUF_VOTE_EN
            // each repetition ends with one low re-arm cycle, except the
            // last one, which goes straight to SEND
            if (rearm) begin
               trig_next = 1'b1;
            end else if (settle_done) begin
               trig_next = 1'b0;
               if (last_rep) begin
                  sample     = 1'b1;
                  state_next = SEND;
               end
            end
`else
            if (settle_done) begin
               sample     = 1'b1;
               trig_next  = 1'b0;
               state_next = SEND;
            end
`endif
         end
         SEND: begin
            start_next = 1'b1;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_rise) begin
               state_next = IDLE;
            end else if ((TX_TIMEOUT > 0) && (to_cnt == TO_LAST)) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // edge-detect registers, challenge/response datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q          <= 1'b0;
         tx_q          <= 1'b0;
         mode_chk      <= 1'b0;
         puf_challenge <= '0;
         puf_trig      <= 1'b0;
         tx_start      <= 1'b0;
         tx_data       <= '0;
      end else begin
         rx_q     <= rx_done;
         tx_q     <= tx_done;
         puf_trig <= trig_next;
         tx_start <= start_next;
         if (accept) begin
            puf_challenge <= rx_data;
            mode_chk      <= check;
         end
         if (load_loop)   tx_data <= RW'(puf_challenge);
         else if (sample) tx_data <= sample_word;
      end
   end

   // settle counter: saturates at SETTLE-1 and clears outside an active trigger phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
`ifdef PUF_VOTE_EN
      end else if (state == EVAL && !rearm) begin
`else
      end else if (state == EVAL) begin
`endif
         if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
      end else begin
         settle_cnt <= '0;
      end
   end

   // transmit timeout counter, counting cycles spent in WAIT_TX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   to_cnt <= '0;
      else if ((TX_TIMEOUT > 0) && state == WAIT_TX) to_cnt <= to_cnt + 1'b1;
      else                                          to_cnt <= '0;
   end

   // sticky error flags; a set in the same cycle as err_clr wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (overrun_set)  err_overrun <= 1'b1;
         else if (err_clr) err_overrun <= 1'b0;
         if (timeout_hit)  err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

`ifdef PUF_VOTE_EN
   // repetition counter, re-arm flag and per-bit ones accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
         rearm   <= 1'b0;
         for (int unsigned i = 0; i < RW; i++) vote_cnt[i] <= '0;
      end else if (state == LOAD) begin
         rep_cnt <= '0;
         rearm   <= 1'b0;
         for (int unsigned i = 0; i < RW; i++) vote_cnt[i] <= '0;
      end else if (settle_done) begin
         rep_cnt <= rep_cnt + 1'b1;
         rearm   <= !last_rep;
         for (int unsigned i = 0; i < RW; i++) vote_cnt[i] <= vote_sum[i];
      end else begin
         rearm <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed, table-driven bench for puf_crp_sequencer (TX_TIMEOUT=20).
// The expectations follow the PUF_VOTE_EN build macro when it is defined.
module tb_puf_crp_sequencer;

   localparam int SETTLE = 8;
`ifdef PUF_VOTE_EN
   localparam int EV_LAT    = 5 * (SETTLE + 1) + 2;
   localparam int EV_TRIG   = 5 * SETTLE;
   localparam int EV_PULSES = 5;
`else
   localparam int EV_LAT    = SETTLE + 3;
   localparam int EV_TRIG   = SETTLE;
   localparam int EV_PULSES = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_done, check, err_clr, tx_done;
   logic [15:0] rx_data;
   logic [31:0] puf_response;
   logic [15:0] puf_challenge;
   logic        puf_trig, tx_start, busy, err_overrun, err_timeout;
   logic [31:0] tx_data;

   int nvec = 0;
   int nerr = 0;
   logic vote_model = 1'b0;

   puf_crp_sequencer #(
      .CW(16), .RW(32), .SETTLE(SETTLE), .TX_TIMEOUT(20), .NUM_EVAL(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
      .check(check), .err_clr(err_clr), .puf_challenge(puf_challenge),
      .puf_trig(puf_trig), .puf_response(puf_response), .tx_start(tx_start),
      .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [15:0] din;
      logic [31:0] resp;
      logic [31:0] exp_tx;
      int          exp_lat;
      int          exp_trig;
      int          exp_pulses;
   } vec_t;

   vec_t vecs [5];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // raise rx_done and follow the DUT until tx_start, measuring latency and trigger activity
   task automatic do_txn(input logic chk, input logic [15:0] din, output int lat,
                         output int trig_cyc, output int pulses, output logic [31:0] txd);
      logic prev;
      prev     = 1'b0;
      lat      = -1;
      trig_cyc = 0;
      pulses   = 0;
      txd      = '0;
      rx_data  = din;
      check    = chk;
      rx_done  = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (puf_trig) trig_cyc++;
         if (puf_trig && !prev) pulses++;
         prev = puf_trig;
         if (vote_model) puf_response = (pulses <= 3) ? 32'hF0F0_F0F0 : 32'h0F0F_0F0F;
         if (c == 2) rx_done = 1'b0;
         if (tx_start) begin
            lat = c;
            txd = tx_data;
            break;
         end
      end
      rx_done = 1'b0;
   endtask

   task automatic finish_txn(input string name);
      tx_done = 1'b1;
      tick();
      cmp(name, {31'd0, busy}, 32'd0);
      tx_done = 1'b0;
      tick();
   endtask

   int          lat, tcyc, pul, n, hits;
   logic [31:0] txd;

   initial begin
      vecs[0] = '{1'b0, 16'hA5C3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, EV_LAT, EV_TRIG, EV_PULSES};
      vecs[1] = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 32'h0000_1234, 3, 0, 0};
      vecs[2] = '{1'b0, 16'hFFFF, 32'h0000_0000, 32'h0000_0000, EV_LAT, EV_TRIG, EV_PULSES};
      vecs[3] = '{1'b0, 16'h0001, 32'h1234_5678, 32'h1234_5678, EV_LAT, EV_TRIG, EV_PULSES};
      vecs[4] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 3, 0, 0};

      rst_n = 1'b0; rx_done = 1'b0; check = 1'b0; err_clr = 1'b0; tx_done = 1'b0;
      rx_data = '0; puf_response = '0;
      repeat (3) tick();
      cmp("rst_outputs", {puf_challenge, 11'd0, puf_trig, tx_start, busy, err_overrun, err_timeout}, 32'd0);
      cmp("rst_tx_data", tx_data, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         puf_response = vecs[i].resp;
         do_txn(vecs[i].chk, vecs[i].din, lat, tcyc, pul, txd);
         cmp($sformatf("v%0d_tx_data", i), txd, vecs[i].exp_tx);
         cmp($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         cmp($sformatf("v%0d_trig_cycles", i), 32'(tcyc), 32'(vecs[i].exp_trig));
         cmp($sformatf("v%0d_trig_pulses", i), 32'(pul), 32'(vecs[i].exp_pulses));
         cmp($sformatf("v%0d_challenge", i), {16'd0, puf_challenge}, {16'd0, vecs[i].din});
         finish_txn($sformatf("v%0d_busy_after_done", i));
      end

      // overrun: a second challenge arrives during EVAL and is dropped
      puf_response = 32'hDEAD_BEEF;
      rx_data = 16'hA5C3; check = 1'b0; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick(); tick(); tick();
      rx_data = 16'h5555; rx_done = 1'b1;
      tick();
      cmp("ovr_flag_set", {31'd0, err_overrun}, 32'd1);
      rx_done = 1'b0;
      puf_response = 32'hDEAD_BEEF;
      n = -1;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (tx_start) begin n = c; break; end
      end
      cmp("ovr_tx_seen", {31'd0, (n > 0)}, 32'd1);
      cmp("ovr_tx_data", tx_data, 32'hDEAD_BEEF);
      cmp("ovr_challenge", {16'd0, puf_challenge}, 32'h0000_A5C3);
      finish_txn("ovr_busy_after_done");
      cmp("ovr_flag_sticky", {31'd0, err_overrun}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      cmp("ovr_flag_clear", {31'd0, err_overrun}, 32'd0);

      // timeout: tx_done never rises
      puf_response = 32'h0BAD_F00D;
      do_txn(1'b0, 16'h0F0F, lat, tcyc, pul, txd);
      cmp("to_latency", 32'(lat), 32'(EV_LAT));
      n = -1;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (!busy) begin n = c; break; end
      end
      cmp("to_cycles_to_idle", 32'(n), 32'd20);
      cmp("to_flag_set", {31'd0, err_timeout}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      cmp("to_flag_clear", {31'd0, err_timeout}, 32'd0);

      // tx_done already high when SEND is reached is not a completion
      tx_done = 1'b1;
      do_txn(1'b0, 16'h3333, lat, tcyc, pul, txd);
      repeat (5) tick();
      cmp("txhigh_still_busy", {31'd0, busy}, 32'd1);
      tx_done = 1'b0;
      tick();
      tx_done = 1'b1;
      tick();
      cmp("txhigh_busy_after_rise", {31'd0, busy}, 32'd0);
      tx_done = 1'b0;
      tick();
      cmp("txhigh_no_timeout", {31'd0, err_timeout}, 32'd0);

      // reset in the middle of EVAL
      puf_response = 32'hCAFE_F00D;
      rx_data = 16'hBEEF; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick(); tick(); tick();
      cmp("rstmid_in_eval", {31'd0, puf_trig}, 32'd1);
      rst_n = 1'b0;
      #1;
      cmp("rstmid_async", {tx_data[31:4], puf_trig, busy, tx_start, 1'b0}, 32'd0);
      cmp("rstmid_tx_data", tx_data, 32'd0);
      tick();
      rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (tx_start || busy) hits++;
      end
      cmp("rstmid_no_restart", 32'(hits), 32'd0);
      puf_response = 32'hDEAD_BEEF;
      do_txn(1'b0, 16'hA5C3, lat, tcyc, pul, txd);
      cmp("rstmid_fresh_latency", 32'(lat), 32'(EV_LAT));
      cmp("rstmid_fresh_tx_data", txd, 32'hDEAD_BEEF);
      finish_txn("rstmid_busy_after_done");

`ifdef PUF_VOTE_EN
      // majority vote: three F0F0F0F0 responses outvote two 0F0F0F0F responses
      vote_model = 1'b1;
      puf_response = 32'hF0F0_F0F0;
      do_txn(1'b0, 16'h7777, lat, tcyc, pul, txd);
      vote_model = 1'b0;
      cmp("vote_tx_data", txd, 32'hF0F0_F0F0);
      cmp("vote_pulses", 32'(pul), 32'd5);
      cmp("vote_trig_cycles", 32'(tcyc), 32'd40);
      cmp("vote_latency", 32'(lat), 32'd47);
      finish_txn("vote_busy_after_done");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
- Control FSM for one PUF challenge-response transaction.
- Receives a challenge word from the UART receiver and drives it onto the PUF challenge bus.
- Triggers evaluation, waits a programmable settle time, captures the response, then hands the response word to the UART transmitter and waits for transmit completion.
- Sits between uart_rx_16, papuf_16_32 and uart_tx_32, replacing the ad-hoc done-delay chain with a deterministic, handshaked sequence.

Parameters:
- CW, 16, challenge width in bits.
- RW, 32, response width in bits.
- SETTLE, 8, clk cycles puf_trig is held high before the response is sampled; legal range 1..255.
- TX_TIMEOUT, 65535, clk cycles to wait for tx_done before aborting; 0 disables the timeout.
- NUM_EVAL, 5, evaluations per challenge when PUF_VOTE_EN is defined; must be odd, 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_done  in  1  UART RX done level; its rising edge marks a new challenge
- rx_data  in  CW  received challenge word, valid at rx_done rising edge
- check  in  1  loopback mode: transmit zero-extended challenge instead of response
- err_clr  in  1  synchronous clear of err_overrun and err_timeout
- puf_challenge  out  CW  registered challenge applied to the PUF
- puf_trig  out  1  PUF evaluate/enable
- puf_response  in  RW  PUF response bus
- tx_start  out  1  one-cycle start pulse to the UART TX
- tx_data  out  RW  word to transmit; stable from tx_start until the FSM returns to IDLE
- tx_done  in  1  UART TX completion level; rising edge ends a transfer
- busy  out  1  high in every state except IDLE
- err_overrun  out  1  sticky: a challenge arrived while busy
- err_timeout  out  1  sticky: tx_done did not rise within TX_TIMEOUT

Behaviour:
- Reset values (async on rst_n low): all outputs 0; state IDLE; all counters 0; edge-detect registers cleared to 0. Reset mid-transaction aborts it immediately. The next transaction requires a fresh rx_done rising edge after reset release.
- Edge detect: rx_done and tx_done are each registered once. A rising edge is current=1 while previous=0. Inputs are already synchronous to clk.
- IDLE: on an rx_done rise, load puf_challenge<=rx_data and latch check into mode_chk, then go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): challenge settles on the PUF inputs. Next state is EVAL, and puf_trig goes 1 on EVAL entry. If mode_chk=1, skip EVAL; tx_data<={zeros,puf_challenge}; go to SEND.
- EVAL: puf_trig=1 and the settle counter counts 0..SETTLE-1. On the cycle the count reaches SETTLE-1, sample puf_response into tx_data, clear puf_trig, and go to SEND. Latency from rx_done rise to tx_start is SETTLE+3 cycles.
- SEND (1 cycle): tx_start=1; the timeout counter is cleared; go to WAIT_TX.
- WAIT_TX: on a tx_done rise, go to IDLE. If TX_TIMEOUT>0 and the counter reaches TX_TIMEOUT, set err_timeout and go to IDLE. A tx_done level already high at SEND is not a rise, so the FSM waits for the next rise.
- Overrun: an rx_done rise in any non-IDLE state sets err_overrun. That challenge is dropped and the current transaction continues unaffected.
- err_clr: clears both error flags on the next clk edge. If a set condition occurs in the same cycle, set wins.
- puf_challenge holds its value after the transaction until the next accepted challenge.
- Widths: counters are sized for their maximum value. The settle counter saturates and never wraps.

Optional Feature:
- Macro: PUF_VOTE_EN.
- Defined: EVAL repeats NUM_EVAL times. Each repetition is SETTLE cycles with puf_trig high, followed by 1 cycle with puf_trig low (re-arm). For every bit, a per-bit counter of width clog2(NUM_EVAL+1) accumulates the ones. After the last repetition, tx_data[i] = (count_i > NUM_EVAL/2). Latency to tx_start is NUM_EVAL*(SETTLE+1)+2 cycles. check mode still bypasses EVAL.
- Undefined: single evaluation as described in Behaviour; no vote counters are synthesised; NUM_EVAL is ignored.

Test Plan:
- Basic flow: rx_data=16'hA5C3, rx_done rise, PUF model returns 32'hDEADBEEF -> puf_trig high exactly 8 cycles; tx_start 11 cycles after the rx_done rise; tx_data=32'hDEADBEEF; busy drops 1 cycle after the tx_done rise.
- Loopback: check=1, rx_data=16'h1234 -> puf_trig never asserted; tx_data=32'h00001234; tx_start 3 cycles after the rx_done rise.
- Overrun: second rx_done rise during EVAL -> err_overrun=1, tx_data unchanged from the first response; err_clr pulse -> err_overrun=0.
- Timeout: TX_TIMEOUT=20, tx_done held 0 -> err_timeout=1 and state IDLE 20 cycles after tx_start; tx_done already high at SEND -> no early exit.
- Reset mid-EVAL: rst_n low for 1 cycle -> puf_trig, busy, tx_start and tx_data all 0 asynchronously; no tx_start follows until a new rx_done rise.
- PUF_VOTE_EN, NUM_EVAL=5: model responses 0xF0F0F0F0 ×3 and 0x0F0F0F0F ×2 -> tx_data=0xF0F0F0F0; puf_trig shows 5 pulses of 8 cycles each.
